// File: rtl/fetch_pkg.sv
// Shared widths, reset constants and the buffered entry type for the fetch prefetch queue.
package fetch_pkg;
    localparam int PC_W    = 32;
    localparam int INSTR_W = 32;

    localparam logic [PC_W-1:0] PC_STEP = 32'd4;
    localparam logic [PC_W-1:0] RST_PC  = 32'h0000_0000;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } fetch_entry_t;

    // Bits needed to hold the values 0..max_val inclusive.
    function automatic int cnt_w(input int max_val);
        return $clog2(max_val + 1);
    endfunction
endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with flush; DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo
    import fetch_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             wr_en, rd_en;

    always_comb begin
        wr_en    = push && !full;
        rd_en    = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Flush wins over any push or pop issued in the same cycle.
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (rd_en) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(wr_en) - CW'(rd_en);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];
endmodule

// File: rtl/fetch_prefetch_queue.sv
// Sequential instruction prefetcher with in-order memory responses, decode hold and redirect flush.
// Optional FETCH_BYPASS_EN forwards a response straight to the output when the buffer is empty.
module fetch_prefetch_queue #(
    parameter int          DEPTH        = 4,
    parameter int          MAX_INFLIGHT = 2,
    parameter logic [31:0] RST_PC       = fetch_pkg::RST_PC,
    parameter logic [31:0] PC_STEP      = fetch_pkg::PC_STEP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        keep,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
);
    import fetch_pkg::*;

    localparam int FW = cnt_w(DEPTH);
    localparam int IW = cnt_w(MAX_INFLIGHT);
    localparam int SW = FW + 1;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [IW-1:0] inflight_q, inflight_d;
    logic [IW-1:0] discard_q, discard_d;

    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [FW-1:0] fifo_count;
    fetch_entry_t  wr_entry, head;

    logic          gnt_fire, rsp_ok, bypass;
    logic [SW-1:0] reserved;

    // Handshakes: a request transfers on a cycle with mem_req && mem_gnt; a response is one
    // mem_rvalid cycle, returned in request order; the head transfers on out_valid && !keep.
    always_comb begin
        rsp_ok   = mem_rvalid && (discard_q == '0) && !redirect;
        // Buffered plus in-flight entries that will actually land in the FIFO.
        reserved = SW'(fifo_count) + SW'(inflight_q) - SW'(discard_q);
        mem_req  = !rst && !redirect && (inflight_q < IW'(MAX_INFLIGHT))
                   && (reserved < SW'(DEPTH)) && !fifo_full;
        mem_addr = fetch_pc_q;
        gnt_fire = mem_req && mem_gnt;
`ifdef FETCH_BYPASS_EN
        bypass   = fifo_empty && rsp_ok;
`else
        bypass   = 1'b0;
`endif
        wr_entry  = '{instr: mem_rdata, pc: resp_pc_q};
        fifo_push = rsp_ok && !(bypass && !keep);
        fifo_pop  = !fifo_empty && !keep && !redirect;
        out_valid = !fifo_empty || bypass;
        out_instr = bypass ? mem_rdata : head.instr;
        out_pc    = bypass ? resp_pc_q : head.pc;

        inflight_d = inflight_q + IW'(gnt_fire) - IW'(mem_rvalid);
        if (redirect) begin
            fetch_pc_d = redirect_pc;
            resp_pc_d  = redirect_pc;
            discard_d  = inflight_q - IW'(mem_rvalid);
        end else begin
            fetch_pc_d = gnt_fire ? fetch_pc_q + PC_STEP : fetch_pc_q;
            resp_pc_d  = rsp_ok ? resp_pc_q + PC_STEP : resp_pc_q;
            discard_d  = (mem_rvalid && discard_q != '0) ? discard_q - IW'(1) : discard_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RST_PC;
            resp_pc_q  <= RST_PC;
            inflight_q <= '0;
            discard_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
        end
    end

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (wr_entry),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue: in-order memory model, issue-order scoreboard, hand-computed checks.
module tb_fetch_prefetch_queue;
    localparam int MAX_INFLIGHT = 2;

    logic        clk = 1'b0;
    logic        rst, redirect, keep, mem_gnt, mem_rvalid;
    logic [31:0] redirect_pc, mem_rdata;
    logic        mem_req, out_valid;
    logic [31:0] mem_addr, out_instr, out_pc;

    always #5 clk = ~clk;

    fetch_prefetch_queue dut (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .keep        (keep),
        .out_valid   (out_valid),
        .out_instr   (out_instr),
        .out_pc      (out_pc)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          due;
    } pend_t;

    pend_t       pend_q[$];
    logic [63:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_pop    = 0;
    int          cycle    = 0;
    int          lat      = 1;
    int          data_mode = 0;
    logic        req_fire, rsp_fire;
    logic [31:0] req_addr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] data_of(input logic [31:0] a);
        case (data_mode)
            1:       return 32'hA0 + (a >> 2);
            2:       return 32'hDEAD_BEEF;
            default: return a ^ 32'hC0DE_0000;
        endcase
    endfunction

    task automatic drive_mem();
        mem_rvalid = (pend_q.size() > 0) && (pend_q[0].due <= cycle);
        mem_rdata  = mem_rvalid ? pend_q[0].data : 32'h0;
    endtask

    // Sample handshakes and score the output away from the active edge.
    task automatic at_neg();
        logic [63:0] e;
        @(negedge clk);
        req_fire = !rst && mem_req && mem_gnt;
        req_addr = mem_addr;
        rsp_fire = mem_rvalid;
        if (!rst && redirect) begin
            check("redir_no_req", 32'(mem_req), 32'd0);
            exp_q.delete();
        end else if (!rst && out_valid && !keep) begin
            if (exp_q.size() == 0) begin
                check("sb_spurious_pop", out_pc, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("sb_pc", out_pc, e[31:0]);
                check("sb_instr", out_instr, e[63:32]);
                n_pop++;
            end
        end
        if (req_fire) exp_q.push_back({data_of(req_addr), req_addr});
    endtask

    task automatic at_pos();
        @(posedge clk);
        #1;
        if (rsp_fire && pend_q.size() > 0) pend_q.delete(0);
        if (req_fire) pend_q.push_back('{req_addr, data_of(req_addr), cycle + lat});
        cycle++;
        if (rst) pend_q.delete();
        check("inflight_max", 32'(pend_q.size() <= MAX_INFLIGHT), 32'd1);
        drive_mem();
    endtask

    task automatic cyc();
        at_neg();
        at_pos();
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        redirect = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
        exp_q.delete();
    endtask

    // Ends right after a negedge sample; caller finishes the cycle with at_pos().
    task automatic wait_valid(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            at_neg();
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
            if (i != budget - 1) at_pos();
        end
    endtask

    initial begin
        bit seen;
        int p0;
        rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; keep = 1'b0;
        mem_gnt = 1'b1; mem_rvalid = 1'b0; mem_rdata = 32'h0;

        // Reset state, then zero-wait streaming.
        cyc();
        at_neg();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_out_instr", out_instr, 32'h0);
        at_pos();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            at_neg();
            check("t1_req", 32'(mem_req), 32'd1);
            check("t1_addr", mem_addr, 32'(i * 4));
            at_pos();
        end
        p0 = n_pop;
        repeat (8) cyc();
        check("t1_throughput", 32'(n_pop - p0), 32'd8);

        // Hold under keep until the buffer saturates, then drain in order.
        data_mode = 1; keep = 1'b1;
        do_reset();
        repeat (10) cyc();
        at_neg();
        check("t2_valid", 32'(out_valid), 32'd1);
        check("t2_req_off", 32'(mem_req), 32'd0);
        check("t2_head_pc", out_pc, 32'h0);
        check("t2_head_instr", out_instr, 32'hA0);
        check("t2_drained", 32'(pend_q.size()), 32'd0);
        at_pos();
        keep = 1'b0;
        for (int i = 0; i < 4; i++) begin
            at_neg();
            check("t2_pop_pc", out_pc, 32'(i * 4));
            check("t2_pop_instr", out_instr, 32'hA0 + 32'(i));
            at_pos();
        end
        repeat (6) cyc();

        // Redirect with two requests outstanding at latency 3.
        data_mode = 0; lat = 3;
        do_reset();
        cyc();
        cyc();
        redirect = 1'b1; redirect_pc = 32'h100;
        at_neg();
        check("t3_inflight", 32'(pend_q.size()), 32'd2);
        at_pos();
        redirect = 1'b0;
        at_neg();
        check("t3_addr", mem_addr, 32'h100);
        check("t3_no_valid", 32'(out_valid), 32'd0);
        at_pos();
        wait_valid(20, seen);
        check("t3_seen", 32'(seen), 32'd1);
        check("t3_pc", out_pc, 32'h100);
        check("t3_instr", out_instr, 32'hC0DE_0100);
        at_pos();
        repeat (10) cyc();

        // Redirect in the same cycle as the only outstanding response.
        lat = 1; mem_gnt = 1'b0;
        do_reset();
        mem_gnt = 1'b1;
        cyc();
        mem_gnt = 1'b0; redirect = 1'b1; redirect_pc = 32'h200;
        at_neg();
        check("t4_inflight", 32'(pend_q.size()), 32'd1);
        at_pos();
        redirect = 1'b0;
        at_neg();
        check("t4_no_valid", 32'(out_valid), 32'd0);
        check("t4_req", 32'(mem_req), 32'd1);
        check("t4_addr", mem_addr, 32'h200);
        at_pos();
        mem_gnt = 1'b1;
        wait_valid(10, seen);
        check("t4_seen", 32'(seen), 32'd1);
        check("t4_pc", out_pc, 32'h200);
        check("t4_instr", out_instr, 32'hC0DE_0200);
        at_pos();
        repeat (4) cyc();

        // Grant withheld: address holds, no PC skip once granted.
        mem_gnt = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            at_neg();
            check("t5_req_hold", 32'(mem_req), 32'd1);
            check("t5_addr_hold", mem_addr, 32'h0);
            at_pos();
        end
        mem_gnt = 1'b1;
        at_neg();
        check("t5_addr_gnt", mem_addr, 32'h0);
        at_pos();
        at_neg();
        check("t5_addr_next", mem_addr, 32'h4);
        at_pos();
        repeat (6) cyc();

        // Single response into an empty buffer: bypass vs registered latency.
        data_mode = 2; mem_gnt = 1'b1;
        do_reset();
        cyc();
        mem_gnt = 1'b0;
        at_neg();
`ifdef FETCH_BYPASS_EN
        check("t6_byp_valid", 32'(out_valid), 32'd1);
        check("t6_byp_instr", out_instr, 32'hDEAD_BEEF);
        check("t6_byp_pc", out_pc, 32'h0);
`else
        check("t6_reg_early", 32'(out_valid), 32'd0);
`endif
        at_pos();
        at_neg();
`ifdef FETCH_BYPASS_EN
        check("t6_byp_count0", 32'(out_valid), 32'd0);
`else
        check("t6_reg_valid", 32'(out_valid), 32'd1);
        check("t6_reg_instr", out_instr, 32'hDEAD_BEEF);
`endif
        at_pos();
        mem_gnt = 1'b1;
        repeat (4) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_prefetch_queue.md
Name: fetch_prefetch_queue

Overview:
- Decouples the fetch stage from an instruction memory with variable, in-order response latency.
- Issues sequential fetch requests, buffers returned instructions with their PCs, and presents them to the IF/ID stage register.
- Holds under decode `keep`.
- On redirect (branch, memory jump, interrupt/exception vector), discards all buffered and in-flight instructions.

Parameters:
- DEPTH, 4, instruction buffer entries (power of two, ≥2)
- MAX_INFLIGHT, 2, maximum outstanding memory requests (≤ DEPTH)
- RST_PC, 32'h0000_0000, fetch PC after reset
- PC_STEP, 4, byte increment between sequential instructions

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous reset, active-high
- redirect  input  1  discard everything; restart fetch at redirect_pc
- redirect_pc  input  32  new fetch address
- mem_req  output  1  request valid
- mem_addr  output  32  request address
- mem_gnt  input  1  request accepted this cycle (only meaningful with mem_req)
- mem_rvalid  input  1  response valid; responses are in request order, ≥1 cycle after grant
- mem_rdata  input  32  response instruction
- keep  input  1  downstream stalled; head is not consumed
- out_valid  output  1  head entry valid
- out_instr  output  32  head instruction
- out_pc  output  32  head instruction PC

Behaviour:
- Reset, applied on the clock edge with rst=1:
  - fetch_pc = resp_pc = RST_PC.
  - count = inflight = discard = 0.
  - FIFO pointers are cleared.
  - out_valid = 0, mem_req = 0; out_instr and out_pc read 0.
  - Reset mid-transfer drops all in-flight state. The memory side is reset with this block.
- Issue:
  - mem_req = !rst && !redirect && (inflight < MAX_INFLIGHT) && (count + inflight - discard < DEPTH).
  - mem_addr = fetch_pc.
  - On mem_req && mem_gnt: fetch_pc += PC_STEP (32-bit wrap) and inflight++.
- Response (mem_rvalid): inflight-- in all cases.
  - If discard > 0: discard--; data is dropped.
  - Otherwise: {mem_rdata, resp_pc} is written at the FIFO tail, then resp_pc += PC_STEP and count++.
- Pop: when out_valid && !keep, the head is removed (count--).
  - Push and pop in the same cycle leave count unchanged.
- Output: out_valid = (count != 0); out_instr and out_pc come from the FIFO head. Latency is one cycle from mem_rvalid to out_valid when the FIFO is empty.
- Redirect has priority over all other events in the same cycle:
  - FIFO is emptied (count = 0, pointers equal); any pop that cycle has no effect.
  - fetch_pc = resp_pc = redirect_pc.
  - discard = inflight − (mem_rvalid ? 1 : 0). A response arriving in the redirect cycle is dropped.
  - No grant is possible that cycle, because mem_req = 0.
  - Back-to-back redirects: the second overrides the first; discard is recomputed from the current inflight.
- Boundaries:
  - The reservation rule guarantees no write to a full FIFO. An overflow is a bench assertion failure.
  - With DEPTH=4 and count=4, mem_req is 0 until a pop occurs.
  - inflight never exceeds MAX_INFLIGHT.
  - mem_rvalid with inflight=0 is illegal (assertion).
  - A grant and a response in the same cycle net to no change in inflight.

Optional Feature:
- Macro FETCH_BYPASS_EN.
- Defined: when count==0 and a non-discarded response arrives, out_valid=1 in the same cycle, with out_instr=mem_rdata and out_pc=resp_pc (combinational bypass).
  - If !keep, the entry is consumed and not written to the FIFO.
  - If keep, it is written normally.
  - The bypass is suppressed when redirect=1.
- Undefined: out_valid is purely registered; response-to-output latency is 1 cycle.

Decomposition:
- Package fetch_pkg:
  - PC_W=32, INSTR_W=32, PC_STEP, RST_PC.
  - Typedef fetch_entry_t {instr, pc}.
  - Counter width function clog2-based for DEPTH and MAX_INFLIGHT.
- Sub-module sync_fifo (generic WIDTH/DEPTH, synchronous reset, flush input, push/pop/full/empty/count) stores fetch_entry_t.
- Issue/discard/PC counters live in the top level.

Test Plan:
- Zero-wait memory (gnt=1, rvalid 1 cycle after grant), keep=0, after reset → mem_addr sequence 0,4,8,12…; out_pc matches with out_instr = mem_rdata; sustained one instruction per cycle once full.
- keep=1 held for 10 cycles, memory returning 0xA0+n → count saturates at 4; mem_req=0; inflight drains to 0; on release out_pc pops 0,4,8,12 in order with no loss.
- Redirect to 0x100 with 2 requests in flight (latency 3) → those 2 responses are dropped (discard 2→0); next out_pc=0x100 with the first post-redirect data; mem_addr=0x100 one cycle after redirect.
- Redirect in the same cycle as mem_rvalid with inflight=1 → discard=0; the returning data is not queued; out_valid=0 next cycle.
- mem_gnt=0 for 5 cycles then 1 → mem_addr held at fetch_pc; only one issue per grant; no PC skip.
- FETCH_BYPASS_EN on, FIFO empty, rvalid with rdata=0xDEAD_BEEF, keep=0 → out_valid=1 and out_instr=0xDEADBEEF in the same cycle; count stays 0. With the macro off → out_valid asserts the next cycle.
